// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants common to the FIFO family
// and a constant-evaluable ceil(log2) helper for sizing.
package fifo_pkg;

  // Read-mode selectors, shared with the async FIFO family
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2; returns 0 for inputs of 0 or 1
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port and one asynchronous
// read port. The array is never reset; occupancy tracking lives in the parent.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the write word on the clock edge when the parent accepts a write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational so FWFT can show the head word directly
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through
// read, programmable almost-full/almost-empty levels, occupancy count and
// sticky overflow/underflow flags. Pointers are binary with a wrap bit.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  // Thresholds narrowed to the count width; legal ranges fit in PTR_W bits
  localparam logic [PTR_W-1:0] AF_LVL = AF_THRESH[PTR_W-1:0];
  localparam logic [PTR_W-1:0] AE_LVL = AE_THRESH[PTR_W-1:0];

  // Reject illegal configurations while elaborating
  if (ADDR_WIDTH < 1 || clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_aw
    $error("sync_fifo_param: ADDR_WIDTH must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      count_q,  count_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status is derived from registered state only, never from wr_en/rd_en
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses pre-edge full/empty, so a same-cycle partner op never rescues a dropped one
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
    // A new error event outranks a clear in the same cycle
    overflow_d  = (overflow_q  && !clr_err) || (wr_en && full);
    underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
  end

  // Controller state; async reset discards all contents at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is shown directly; meaningful only while not empty
    assign rd_data = mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Capture the head word on an accepted read, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (rd_acc) begin
        rd_data_q <= mem_rdata;
      end
    end

    assign rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one
// stimulus stream and are checked every cycle against a queue model, with
// literal expectations from the directed scenarios alongside.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic [AW:0]   count0, count1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                    .AF_THRESH(6), .AE_THRESH(1)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0),
    .clr_err(clr_err));

  sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                    .AF_THRESH(6), .AE_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1),
    .clr_err(clr_err));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, last popped word, sticky flags
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_udf;

  always @(posedge clk or posedge rst) begin
    int  sz;
    bit  wa, ra;
    if (rst) begin
      m_q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      sz = m_q.size();
      wa = wr_en && (sz != DEPTH);
      ra = rd_en && (sz != 0);
      m_ovf = (m_ovf && !clr_err) || (wr_en && sz == DEPTH);
      m_udf = (m_udf && !clr_err) || (rd_en && sz == 0);
      if (ra) m_rd = m_q.pop_front();
      if (wa) m_q.push_back(wr_data);
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int sz;
    if (chk_on) begin
      sz = m_q.size();
      chk("count0", int'(count0), sz);
      chk("count1", int'(count1), sz);
      chk("empty0", int'(empty0), int'(sz == 0));
      chk("empty1", int'(empty1), int'(sz == 0));
      chk("full0",  int'(full0),  int'(sz == DEPTH));
      chk("full1",  int'(full1),  int'(sz == DEPTH));
      chk("afull0", int'(af0),    int'(sz >= 6));
      chk("aempty0", int'(ae0),   int'(sz <= 1));
      chk("afull1", int'(af1),    int'(sz >= 6));
      chk("aempty1", int'(ae1),   int'(sz <= 1));
      chk("ovf0",   int'(ovf0),   int'(m_ovf));
      chk("udf0",   int'(udf0),   int'(m_udf));
      chk("ovf1",   int'(ovf1),   int'(m_ovf));
      chk("udf1",   int'(udf1),   int'(m_udf));
      chk("rdata_std", int'(rd_data0), int'(m_rd));
      if (sz != 0) chk("rdata_fwft", int'(rd_data1), int'(m_q[0]));
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step(0, 8'h00, 0, 0);

    // Reset state
    chk("rst_count", int'(count0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_aempty", int'(ae0), 1);
    chk("rst_full", int'(full0), 0);
    chk("rst_afull", int'(af0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    chk("rst_udf", int'(udf0), 0);
    chk("rst_rdata", int'(rd_data0), 0);

    // Underflow, clear, and set-beats-clear
    step(0, 8'h00, 1, 0);
    chk("udf_set", int'(udf0), 1);
    chk("udf_count", int'(count0), 0);
    chk("udf_empty", int'(empty0), 1);
    step(0, 8'h00, 0, 1);
    chk("udf_clr", int'(udf0), 0);
    step(0, 8'h00, 1, 1);
    chk("udf_set_wins", int'(udf0), 1);
    step(0, 8'h00, 0, 1);

    // Fill 0x10..0x17, then overflow with 0xFF
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h10 + i), 0, 0);
      chk("fill_afull", int'(af0), int'(i + 1 >= 6));
    end
    chk("fill_full", int'(full0), 1);
    chk("fill_count", int'(count0), 8);
    step(1, 8'hFF, 0, 0);
    chk("ovf_set", int'(ovf0), 1);
    chk("ovf_count", int'(count0), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_fwft", int'(rd_data1), 8'h10 + i);
      step(0, 8'h00, 1, 0);
      chk("drain_std", int'(rd_data0), 8'h10 + i);
    end
    chk("drain_empty", int'(empty0), 1);
    step(0, 8'h00, 0, 1);

    // Simultaneous read/write while full: write dropped, read taken
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'hEE, 1, 0);
    chk("full_rw_count", int'(count0), 7);
    chk("full_rw_ovf", int'(ovf0), 1);
    chk("full_rw_data", int'(rd_data0), 8'h40);
    for (int i = 1; i < 8; i++) begin
      step(0, 8'h00, 1, 0);
      chk("full_rw_drain", int'(rd_data0), 8'h40 + i);
    end

    // Simultaneous read/write while empty: read dropped, write taken
    step(1, 8'h55, 1, 1);
    chk("empty_rw_count", int'(count0), 1);
    chk("empty_rw_udf", int'(udf0), 1);
    chk("empty_rw_hold", int'(rd_data0), 8'h47);
    step(0, 8'h00, 1, 1);
    chk("empty_rw_data", int'(rd_data0), 8'h55);

    // Steady state at count 4 for 20 cycles
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h24 + i), 1, 0);
      chk("steady_count", int'(count0), 4);
      chk("steady_data", int'(rd_data0), 8'h20 + i);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    chk("steady_empty", int'(empty0), 1);

    // Wrap-around streaming of 0..29
    step(1, 8'd0, 0, 0);
    for (int i = 1; i < 30; i++) begin
      step(1, 8'(i), 1, 0);
      chk("wrap_count", int'(count0), 1);
      chk("wrap_data", int'(rd_data0), i - 1);
    end
    step(0, 8'h00, 1, 0);
    chk("wrap_last", int'(rd_data0), 29);
    chk("wrap_empty", int'(empty0), 1);

    // FWFT single word
    step(1, 8'hA5, 0, 0);
    chk("fwft_data", int'(rd_data1), 8'hA5);
    chk("fwft_nempty", int'(empty1), 0);
    step(0, 8'h00, 1, 0);
    chk("fwft_popped", int'(empty1), 1);

    // Async reset mid-burst at count 5
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0);
    chk("pre_rst_count", int'(count0), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count0), 0);
    chk("arst_empty", int'(empty0), 1);
    chk("arst_aempty", int'(ae0), 1);
    chk("arst_rdata", int'(rd_data0), 0);
    chk("arst_fwft_empty", int'(empty1), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 8'h3C, 0, 0);
    chk("post_rst_fwft", int'(rd_data1), 8'h3C);
    step(0, 8'h00, 1, 0);
    chk("post_rst_data", int'(rd_data0), 8'h3C);
    step(0, 8'h00, 0, 0);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO: the single-domain successor to the team's two-clock FIFO. Adds configurable width and depth, a first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It is used wherever producer and consumer share one clock, so no pointer Gray-coding or synchronisers are needed.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH (derived, not overridable)
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read/pop request
- rd_data  out  DATA_WIDTH  read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Pointers wr_ptr and rd_ptr are binary, ADDR_WIDTH+1 bits. The memory index is the low ADDR_WIDTH bits; the MSB is the wrap bit.
- full: MSBs differ and low bits are equal. empty: pointers are equal. Both are derived from registered pointers only.
- Write is accepted when wr_en && !full. Read is accepted when rd_en && !empty.
- Acceptance is decided on pre-edge state:
  - A write while full is dropped, even if a read is accepted in the same cycle.
  - A read while empty is dropped, even if a write is accepted in the same cycle.
- count register: +1 on write only, -1 on read only, unchanged when both or neither are accepted. Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR_WIDTH+1)).
- Pointers wrap naturally: DEPTH-1 -> 0 in the low bits, with the MSB toggling.
- Standard mode (FWFT=0):
  - An accepted read registers mem[rd_ptr] into rd_data at that edge.
  - rd_data otherwise holds its value.
- FWFT mode:
  - rd_data = mem[rd_ptr] combinationally.
  - Valid whenever !empty; rd_en acknowledges and pops the displayed word.
  - rd_data is don't-care while empty.
- Error flags:
  - overflow is set on wr_en && full; underflow is set on rd_en && empty.
  - Both are cleared by clr_err. Set wins over a same-cycle clear.
- Reset: pointers, count and rd_data = 0; empty = 1, almost_empty = 1; full, almost_full, overflow, underflow = 0. Memory contents are not reset.
- Reset mid-operation discards all contents immediately (asynchronous). The first write after deassertion is the first word read.

## Timing
- All flags and count change only after a clk edge; none depend combinationally on wr_en or rd_en.
- Write to read, standard mode:
  - A word written at edge N is first readable by a rd_en sampled at edge N+1.
  - Its data appears on rd_data after that read edge (2 edges minimum).
- Write to read, FWFT: a word written at edge N into an empty FIFO is on rd_data, with empty = 0, after edge N. Latency is 1 edge.
- full asserts after the edge accepting the DEPTH-th write. It deasserts after the first accepted read.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg holds:
  - clog2 helper function
  - FIFO mode constants (FIFO_STD = 0, FIFO_FWFT = 1), shared with the async FIFO family
- Sub-module fifo_mem_dp: simple dual-port memory with synchronous write and asynchronous read. The parent adds the rd_data register for FWFT=0.
- The controller (pointers, count, flags, error logic) lives in sync_fifo_param itself. The parameter legality check is an elaboration-time assertion.

## Test plan
All scenarios use defaults DATA_WIDTH=8, ADDR_WIDTH=3 (DEPTH 8), AF_THRESH=6, AE_THRESH=1.
- Fill 8 words 0x10..0x17 with no reads, then one extra write of 0xFF:
  - full=1, count=8, almost_full high from count=6, overflow=1.
  - Drain returns 0x10..0x17 in order; 0xFF is never seen.
- Read on an empty FIFO after reset: underflow=1, count stays 0, empty stays 1. Pulsing clr_err clears underflow. A same-cycle clr_err and bad read leaves underflow=1.
- Simultaneous wr_en/rd_en:
  - With count=4 for 20 cycles: count stays 4 and data order is preserved.
  - When full: write dropped, read accepted, count=7.
  - When empty: read dropped, write accepted, count=1.
- Wrap-around: push and pop 1 word per cycle for 30 words, values 0..29. Output sequence is 0..29 exactly, wr_ptr wraps through 16 and count never exceeds 1.
- FWFT=1: write 0xA5 to an empty FIFO. rd_data=0xA5 and empty=0 after that edge. Asserting rd_en pops it, and empty=1 on the next edge.
- Assert rst asynchronously mid-burst with count=5: outputs return to reset values without a clk edge. The next written word 0x3C is the next word read.
